// File: rtl/sysbus_pkg.sv
// sysbus_pkg: shared system-bus definitions for the memory responder and
// mod_icache.  Holds the line geometry, the tag type and the responder
// state encoding.
package sysbus_pkg;

  localparam int unsigned BEATS_PER_LINE = 8;
  localparam int unsigned BEAT_BITS      = 64;
  localparam int unsigned LINE_BYTES     = 64;
  localparam int unsigned SYSBUS_TAG_W   = 13;

  typedef logic [SYSBUS_TAG_W-1:0] sysbus_tag_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } resp_state_e;

  // Word-within-line for beat k when the burst starts at word 'crit'.
  // The 3-bit sum wraps naturally inside the 8-word line.
  function automatic logic [2:0] beat_word(input logic [2:0] crit,
                                           input logic [2:0] k);
    return crit + k;
  endfunction

endpackage

// File: rtl/sysbus_mem_responder_store.sv
// mem_responder_store: 1R1W synchronous word array backing the responder.
//   clk, reset   : clock / synchronous active-high reset (read register only;
//                  array contents are never cleared)
//   i_wr_en      : write strobe
//   i_wr_addr    : write word address
//   i_wr_data    : write data
//   i_rd_en      : read strobe; o_rd_data updates on the following edge
//   i_rd_addr    : read word address
//   o_rd_data    : registered read data, held while i_rd_en is low
module mem_responder_store #(
  parameter int unsigned LOG_MEM_WORDS = 12,
  parameter int unsigned DATA_W        = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wr_en,
  input  logic [LOG_MEM_WORDS-1:0] i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_rd_en,
  input  logic [LOG_MEM_WORDS-1:0] i_rd_addr,
  output logic [DATA_W-1:0]        o_rd_data
);

  localparam int unsigned DEPTH = 1 << LOG_MEM_WORDS;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: memory-side responder for instruction-cache line
// fills.  One request at a time; a read returns a 64-byte line as eight
// 64-bit beats after LATENCY cycles, a write stores a single 64-bit word.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   req         : request valid (held by requester until reqack)
//   reqwrite    : 1 = single-word write, 0 = line read
//   reqaddr     : byte address (reads: line [63:6], writes: word [63:3])
//   reqdata     : write data
//   reqtag      : read tag, echoed on resptag
//   reqack      : one-cycle registered pulse, request consumed
//   respcyc     : response beat valid
//   resp        : response beat data
//   resptag     : tag of the read in flight
//   respack     : requester consumed the current beat
//
// Build option: define SYSBUS_CRIT_WORD_FIRST_EN to start each burst at the
// requested word (wrapping within the line); otherwise beats are in linear
// order starting at word 0.
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int unsigned LATENCY       = 4,
  parameter int unsigned LOG_MEM_WORDS = 12,
  parameter int unsigned TAG_W         = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             reqwrite,
  input  logic [63:0]      reqaddr,
  input  logic [63:0]      reqdata,
  input  logic [TAG_W-1:0] reqtag,
  output logic             reqack,
  output logic             respcyc,
  output logic [63:0]      resp,
  output logic [TAG_W-1:0] resptag,
  input  logic             respack
);

  localparam int unsigned LINE_W = LOG_MEM_WORDS - 3;

  resp_state_e        r_state;
  logic [7:0]         r_lat_cnt;
  logic [2:0]         r_beat_cnt;
  logic [LINE_W-1:0]  r_line;
  logic [TAG_W-1:0]   r_tag;
  logic               r_reqack;
  logic               r_respcyc;
`ifdef SYSBUS_CRIT_WORD_FIRST_EN
  logic [2:0]         r_crit;
`endif

  logic                     w_accept;
  logic                     w_wr_en;
  logic [LOG_MEM_WORDS-1:0] w_wr_addr;
  logic                     w_beat_ack;
  logic                     w_last;
  logic [2:0]               w_next_beat;
  logic [2:0]               w_rd_word;
  logic                     w_rd_en;
  logic [LOG_MEM_WORDS-1:0] w_rd_addr;
  logic [63:0]              w_rd_data;
  logic                     w_unused;

  // The registered reqack is still high in the cycle after an accept while
  // the requester has not yet dropped req; gating on it keeps a write (which
  // stays in IDLE) from being taken twice.
  assign w_accept   = (r_state == IDLE) && req && !r_reqack;
  assign w_wr_en    = w_accept && reqwrite;
  assign w_wr_addr  = reqaddr[3 +: LOG_MEM_WORDS];
  assign w_beat_ack = (r_state == BURST) && r_respcyc && respack;
  assign w_last     = (r_beat_cnt == 3'd7);

  // The store has one cycle of read latency, so the read for the beat that
  // will be shown next is issued in the cycle before it appears: beat 0 on
  // the final WAIT cycle, beat k+1 on the cycle beat k is acknowledged.
  assign w_next_beat = (r_state == WAIT) ? 3'd0 : (r_beat_cnt + 3'd1);
  assign w_rd_en     = ((r_state == WAIT) && (r_lat_cnt == 8'd0)) ||
                       (w_beat_ack && !w_last);
`ifdef SYSBUS_CRIT_WORD_FIRST_EN
  assign w_rd_word   = beat_word(r_crit, w_next_beat);
`else
  assign w_rd_word   = beat_word(3'd0, w_next_beat);
`endif
  assign w_rd_addr   = {r_line, w_rd_word};

  // Address bits outside the store are ignored so accesses wrap.
  assign w_unused = &{1'b0, reqaddr[63:LOG_MEM_WORDS+3], reqaddr[2:0]};

  mem_responder_store #(
    .LOG_MEM_WORDS (LOG_MEM_WORDS),
    .DATA_W        (BEAT_BITS)
  ) u_store (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (reqdata),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_lat_cnt  <= '0;
      r_beat_cnt <= '0;
      r_line     <= '0;
      r_tag      <= '0;
      r_reqack   <= 1'b0;
      r_respcyc  <= 1'b0;
`ifdef SYSBUS_CRIT_WORD_FIRST_EN
      r_crit     <= '0;
`endif
    end else begin
      r_reqack <= w_accept;
      case (r_state)
        IDLE: begin
          if (w_accept && !reqwrite) begin
            r_line    <= reqaddr[6 +: LINE_W];
            r_tag     <= reqtag;
`ifdef SYSBUS_CRIT_WORD_FIRST_EN
            r_crit    <= reqaddr[5:3];
`endif
            r_lat_cnt <= 8'(LATENCY - 1);
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (r_lat_cnt == 8'd0) begin
            r_state    <= BURST;
            r_respcyc  <= 1'b1;
            r_beat_cnt <= '0;
          end else begin
            r_lat_cnt <= r_lat_cnt - 8'd1;
          end
        end
        BURST: begin
          if (w_beat_ack) begin
            if (w_last) begin
              r_respcyc <= 1'b0;
              r_state   <= IDLE;
            end else begin
              r_beat_cnt <= r_beat_cnt + 3'd1;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_respcyc <= 1'b0;
        end
      endcase
    end
  end

  assign reqack  = r_reqack;
  assign respcyc = r_respcyc;
  assign resp    = w_rd_data;
  assign resptag = r_tag;

endmodule
